// File: rtl/cached_ram_pkg.sv
// Shared widths, mode encodings and word types
// for the cached data-memory model.
package cached_ram_pkg;

  localparam int CACHE_LINES_D = 64;
  localparam int INDEX_W_D     = 6;
  localparam int ADDR_W_D      = 12;
  localparam int TAG_W_D       = 6;
  localparam int WORD_W        = 32;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  typedef logic [TAG_W_D-1:0]   tag_t;
  typedef logic [INDEX_W_D-1:0] index_t;
  typedef logic [WORD_W-1:0]    word_t;

endpackage

// File: rtl/cached_ram_sp_ram.sv
// Single-port backing store: async read,
// sync write.
module sp_ram
  import cached_ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_D
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  word_t             wdata,
  output word_t             rdata
);

  word_t mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/cached_ram.sv
// Word RAM behind a direct-mapped, write-through,
// read-allocate cache with change-triggered access.
module cached_ram
  import cached_ram_pkg::*;
#(
  parameter int CACHE_LINES = CACHE_LINES_D,
  parameter int INDEX_W     = INDEX_W_D,
  parameter int ADDR_W      = ADDR_W_D,
  parameter int TAG_W       = TAG_W_D
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] address,
  input  word_t       data,
  input  logic        mode,
  output word_t       out,
  output logic        hit
);

  logic [ADDR_W-1:0]  ea;
  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tg;

  logic [ADDR_W-1:0]  last_ea;
  word_t              last_data;
  logic               last_mode;
  logic               primed;

  logic [CACHE_LINES-1:0] valid;
  logic [TAG_W-1:0]       tag_arr [CACHE_LINES];
  word_t                  line    [CACHE_LINES];

  logic  same;
  logic  accept;
  logic  lookup;
  logic  is_wr;
  logic  ram_we;
  logic  fill;
  logic  wr_hit;
  word_t ram_rdata;
  logic  unused_hi;

  assign ea  = address[ADDR_W-1:0];
  assign idx = ea[INDEX_W-1:0];
  assign tg  = ea[ADDR_W-1:INDEX_W];

  // Upper address bits alias onto the same word.
  assign unused_hi = ^address[31:ADDR_W];

  assign same = primed
             && (ea == last_ea)
             && (data == last_data)
             && (mode == last_mode);

  assign accept = !same;
  assign is_wr  = (mode == MODE_WRITE);
  assign lookup = valid[idx]
               && (tag_arr[idx] == tg);

  assign ram_we = rst_n && accept && is_wr;
  assign fill   = accept && !is_wr && !lookup;
  assign wr_hit = accept && is_wr && lookup;

  sp_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ea),
    .wdata (data),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid     <= '0;
      out       <= '0;
      hit       <= 1'b0;
      last_ea   <= '0;
      last_data <= '0;
      last_mode <= MODE_READ;
      primed    <= 1'b0;
    end else if (accept) begin
      hit       <= lookup;
      last_ea   <= ea;
      last_data <= data;
      last_mode <= mode;
      primed    <= 1'b1;
      if (!is_wr) begin
        out <= lookup ? line[idx]
                      : ram_rdata;
      end
      if (fill) begin
        valid[idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays are not reset, but an
  // edge with reset asserted must not update them.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      unique case (1'b1)
        fill: begin
          tag_arr[idx] <= tg;
          line[idx]    <= ram_rdata;
        end
        wr_hit: begin
          line[idx] <= data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cached_ram.sv
// Directed test of cached_ram against an
// address-residency model of the cache.
module tb_cached_ram;

  logic        clk;
  logic        rst_n;
  logic [31:0] address;
  logic [31:0] data;
  logic        mode;
  logic [31:0] out;
  logic        hit;

  int total = 0;
  int bad   = 0;
  bit checking = 0;

  cached_ram dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .address (address),
    .data    (data),
    .mode    (mode),
    .out     (out),
    .hit     (hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] ram_m [4096];
  int          res   [64];
  logic [31:0] m_out;
  logic        m_hit;
  bit          m_primed;
  logic [11:0] l_ea;
  logic [31:0] l_data;
  logic        l_mode;

  initial begin
    for (int i = 0; i < 4096; i++) ram_m[i] = '0;
  end

  // The model tracks which address each line
  // holds; write-through keeps line == RAM.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_out = '0;
      m_hit = 1'b0;
      m_primed = 0;
      l_ea = '0;
      l_data = '0;
      l_mode = 1'b0;
      for (int i = 0; i < 64; i++) res[i] = -1;
    end else begin
      automatic int ea = int'(address % 4096);
      automatic int ix = ea % 64;
      if (!m_primed || ea != int'(l_ea)
          || data != l_data || mode != l_mode) begin
        m_hit = (res[ix] == ea);
        if (mode) begin
          ram_m[ea] = data;
        end else begin
          if (!m_hit) res[ix] = ea;
          m_out = ram_m[ea];
        end
        l_ea = ea[11:0];
        l_data = data;
        l_mode = mode;
        m_primed = 1;
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h",
               nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (checking && rst_n) begin
      chk("cyc_out", out, m_out);
      chk("cyc_hit", {31'd0, hit}, {31'd0, m_hit});
    end
  end

  task automatic op(input logic [31:0] a,
                    input logic [31:0] d,
                    input logic        m);
    address = a;
    data    = d;
    mode    = m;
    @(negedge clk);
  endtask

  task automatic lit(input string nm,
                     input logic [31:0] eo,
                     input logic        eh);
    chk({nm, "_out"}, out, eo);
    chk({nm, "_hit"}, {31'd0, hit}, {31'd0, eh});
    chk({nm, "_mout"}, m_out, eo);
  endtask

  logic [31:0] atab [6];

  initial begin
    rst_n   = 1'b0;
    address = '0;
    data    = '0;
    mode    = 1'b0;
    repeat (2) @(negedge clk);
    lit("reset", 32'h0, 1'b0);
    rst_n = 1'b1;
    checking = 1;

    op(32'h000, 32'h0, 1'b0);
    lit("rd0", 32'h0, 1'b0);
    op(32'h005, 32'hDEADBEEF, 1'b1);
    lit("wr5_miss", 32'h0, 1'b0);
    op(32'h005, 32'h0, 1'b0);
    lit("rd5_fill", 32'hDEADBEEF, 1'b0);
    op(32'h005, 32'h1, 1'b0);
    lit("rd5_hit", 32'hDEADBEEF, 1'b1);
    op(32'h045, 32'h0, 1'b0);
    lit("rd45_conf", 32'h0, 1'b0);
    op(32'h005, 32'h0, 1'b0);
    lit("rd5_evict", 32'hDEADBEEF, 1'b0);
    op(32'h010, 32'h0, 1'b0);
    lit("rd10", 32'h0, 1'b0);
    op(32'h010, 32'hCAFEF00D, 1'b1);
    lit("wr10_hit", 32'h0, 1'b1);
    op(32'h010, 32'h0, 1'b0);
    lit("rd10_wt", 32'hCAFEF00D, 1'b1);
    op(32'h1005, 32'h12345678, 1'b1);
    lit("wr_alias", 32'hCAFEF00D, 1'b1);
    repeat (5) begin
      @(negedge clk);
      lit("hold", 32'hCAFEF00D, 1'b1);
    end
    op(32'h005, 32'h0, 1'b0);
    lit("rd5_alias", 32'h12345678, 1'b1);
    @(negedge clk);
    lit("dup_rd", 32'h12345678, 1'b1);

    #2 rst_n = 1'b0;
    #1 lit("async_rst", 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    op(32'h000, 32'h0, 1'b0);
    lit("first_rd0", 32'h0, 1'b0);
    op(32'h010, 32'h0, 1'b0);
    lit("rd10_kept", 32'hCAFEF00D, 1'b0);
    op(32'h000, 32'h0, 1'b0);
    lit("rd0_hit", 32'h0, 1'b1);
    op(32'h005, 32'h0, 1'b0);
    lit("rd5_kept", 32'h12345678, 1'b0);

    atab[0] = 32'h005;
    atab[1] = 32'h045;
    atab[2] = 32'h1085;
    atab[3] = 32'h010;
    atab[4] = 32'h2010;
    atab[5] = 32'h03F;
    for (int i = 0; i < 40; i++) begin
      op(atab[$urandom_range(0, 5)],
         $urandom_range(0, 3),
         1'($urandom_range(0, 1)));
    end

    checking = 0;
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
